// File: rtl/fp_pkg.sv
// Shared constants for the float add/sub output path: operand type codes,
// field widths, FSM state codes and status flag bit positions.
package fp_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 28;
  localparam int FP_BIAS   = 127;

  typedef enum logic [2:0] {
    TYPE_ZERO   = 3'b000,
    TYPE_NORMAL = 3'b001,
    TYPE_INF    = 3'b010,
    TYPE_NAN    = 3'b011
  } fp_type_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_NORM  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // out_flags = {overflow, underflow, inexact, zero}
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_INX  = 1;
  localparam int FLAG_UNF  = 2;
  localparam int FLAG_OVF  = 3;

endpackage

// File: rtl/leading_zero_counter.sv
// Counts leading zeros of a 28-bit mantissa; returns 28 for an all-zero input.
module leading_zero_counter (
  input  logic [27:0] i_data,
  output logic [4:0]  o_count
);

  // Later (higher) set bits overwrite earlier ones, so the MSB-most one wins.
  always_comb begin
    o_count = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (i_data[i]) o_count = 5'(27 - i);
    end
  end

endmodule

// File: rtl/normalize_pack.sv
// Post-adder normalize / round-to-nearest-even / IEEE-754 pack stage.
// Define NORM_FAST_EN for one-cycle LZC + barrel-shift normalization.
module normalize_pack
  import fp_pkg::*;
#(
  parameter int EXP_W  = FP_EXP_W,
  parameter int MANT_W = FP_MANT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mantis,
  input  logic [2:0]        in_type,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [3:0]        out_flags
);

  logic [1:0]  r_state;
  logic        r_sign;
  logic [8:0]  r_exp;
  logic [27:0] r_mant;
  logic [31:0] r_result;
  logic [3:0]  r_flags;

  // Rounding operates on bits 27:3 (carry, hidden, 23-bit fraction).
  logic        w_round_up;
  logic        w_inexact;
  logic [24:0] w_mant_sum;
  logic [8:0]  w_exp_rnd;
  logic [22:0] w_frac;
  logic        w_ovf;
  logic [31:0] w_packed;
  logic [3:0]  w_flags;

  assign w_round_up = r_mant[2] & (r_mant[1] | r_mant[0] | r_mant[3]);
  assign w_inexact  = |r_mant[2:0];
  assign w_mant_sum = r_mant[27:3] + {24'b0, w_round_up};

  always_comb begin
    w_exp_rnd = r_exp;
    w_frac    = w_mant_sum[22:0];
    if (w_mant_sum[24]) begin
      w_exp_rnd = r_exp + 9'd1;
      w_frac    = '0;
    end else if (!w_mant_sum[23]) begin
      w_exp_rnd = '0;
    end
  end

  assign w_ovf = (w_exp_rnd >= 9'd255);

  always_comb begin
    w_packed = {r_sign, w_exp_rnd[7:0], w_frac};
    w_flags  = '0;
    if (w_ovf) begin
      w_packed           = {r_sign, 8'hFF, 23'b0};
      w_flags[FLAG_OVF]  = 1'b1;
      w_flags[FLAG_INX]  = 1'b1;
    end else begin
      w_flags[FLAG_INX]  = w_inexact;
      w_flags[FLAG_UNF]  = (w_exp_rnd == 9'd0) & w_inexact;
      w_flags[FLAG_ZERO] = (w_exp_rnd == 9'd0) & (w_frac == 23'd0);
    end
  end

`ifdef NORM_FAST_EN
  logic [4:0] w_lzc;
  logic [4:0] w_lz_m1;
  logic [8:0] w_exp_room;
  logic [4:0] w_shamt;

  leading_zero_counter u_lzc (
    .i_data  (r_mant),
    .o_count (w_lzc)
  );

  // Left shift is clamped so the exponent never drops below 1.
  assign w_lz_m1    = w_lzc - 5'd1;
  assign w_exp_room = (r_exp > 9'd1) ? (r_exp - 9'd1) : 9'd0;
  assign w_shamt    = ({4'b0, w_lz_m1} > w_exp_room) ? w_exp_room[4:0] : w_lz_m1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_mant   <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign <= in_sign;
            r_exp  <= 9'(in_exp);
            r_mant <= 28'(in_mantis);
            if (in_type == TYPE_NAN || in_type[2]) begin
              r_result <= 32'h7FC0_0000;
              r_flags  <= '0;
              r_state  <= ST_DONE;
            end else if (in_type == TYPE_INF) begin
              r_result <= {in_sign, 8'hFF, 23'b0};
              r_flags  <= '0;
              r_state  <= ST_DONE;
            end else if (in_type == TYPE_ZERO || in_mantis == '0) begin
              r_result           <= {in_sign, 31'b0};
              r_flags            <= '0;
              r_flags[FLAG_ZERO] <= 1'b1;
              r_state            <= ST_DONE;
            end else begin
              r_state <= ST_NORM;
            end
          end
        end
        ST_NORM: begin
`ifdef NORM_FAST_EN
          if (r_mant[27]) begin
            r_mant <= {1'b0, r_mant[27:2], r_mant[1] | r_mant[0]};
            r_exp  <= r_exp + 9'd1;
          end else begin
            r_mant <= r_mant << w_shamt;
            r_exp  <= r_exp - {4'b0, w_shamt};
          end
          r_state <= ST_ROUND;
`else
          if (r_mant[27]) begin
            r_mant <= {1'b0, r_mant[27:2], r_mant[1] | r_mant[0]};
            r_exp  <= r_exp + 9'd1;
          end else if (!r_mant[26] && (|r_mant) && (r_exp > 9'd1)) begin
            r_mant <= {r_mant[26:0], 1'b0};
            r_exp  <= r_exp - 9'd1;
          end else begin
            r_state <= ST_ROUND;
          end
`endif
        end
        ST_ROUND: begin
          r_result <= w_packed;
          r_flags  <= w_flags;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign out_result = r_result;
  assign out_flags  = r_flags;

endmodule

// File: tb/tb_normalize_pack.sv
// Directed-vector bench for normalize_pack; latency expectations follow NORM_FAST_EN.
module tb_normalize_pack;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_mantis;
  logic [2:0]  in_type;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef NORM_FAST_EN
  localparam int LAT_RSHIFT = 3;
  localparam int LAT_LONG   = 3;
`else
  localparam int LAT_RSHIFT = 4;
  localparam int LAT_LONG   = 26;
`endif

  normalize_pack dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mantis  (in_mantis),
    .in_type    (in_type),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive(input logic s, input logic [7:0] e, input logic [27:0] m,
                       input logic [2:0] t);
    @(negedge clk);
    in_sign   = s;
    in_exp    = e;
    in_mantis = m;
    in_type   = t;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic s, input logic [7:0] e,
                         input logic [27:0] m, input logic [2:0] t,
                         input logic [31:0] exp_res, input logic [3:0] exp_flg,
                         input int exp_lat);
    int lat;
    drive(s, e, m, t);
    wait_valid(lat);
    $display("vec %-10s exp=%0d mant=%h type=%0d -> result=%h flags=%b lat=%0d",
             tag, e, m, t, out_result, out_flags, lat);
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".res"}, out_result, exp_res);
    check({tag, ".flg"}, 32'(out_flags), 32'(exp_flg));
    release_out();
    check({tag, ".rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mantis = '0;
    in_type   = 3'b000;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.result", out_result, 32'h0);
    check("rst.flags", 32'(out_flags), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_vec("one",     1'b0, 8'd127, 28'h4000000, 3'b001, 32'h3F800000, 4'b0000, 3);
    run_vec("two",     1'b0, 8'd127, 28'h8000000, 3'b001, 32'h40000000, 4'b0000, LAT_RSHIFT);
    run_vec("ovf",     1'b0, 8'd254, 28'h8000000, 3'b001, 32'h7F800000, 4'b1010, LAT_RSHIFT);
    run_vec("rsh_rnd", 1'b0, 8'd127, 28'h800000C, 3'b001, 32'h40000001, 4'b0010, LAT_RSHIFT);
    run_vec("lsh23",   1'b0, 8'd130, 28'h0000008, 3'b001, 32'h35800000, 4'b0000, LAT_LONG);
    run_vec("tie_even",1'b0, 8'd127, 28'h4000004, 3'b001, 32'h3F800000, 4'b0010, 3);
    run_vec("tie_up",  1'b0, 8'd127, 28'h400000C, 3'b001, 32'h3F800002, 4'b0010, 3);
    run_vec("denorm",  1'b0, 8'd1,   28'h2000004, 3'b001, 32'h00400000, 4'b0110, 3);
    run_vec("nan",     1'b0, 8'd0,   28'h0000000, 3'b011, 32'h7FC00000, 4'b0000, 1);
    run_vec("negzero", 1'b1, 8'd0,   28'h0000000, 3'b000, 32'h80000000, 4'b0001, 1);
    run_vec("neginf",  1'b1, 8'd0,   28'h0000000, 3'b010, 32'hFF800000, 4'b0000, 1);
    run_vec("zmant",   1'b0, 8'd90,  28'h0000000, 3'b001, 32'h00000000, 4'b0001, 1);

    // Backpressure: result must hold while a competing input is ignored.
    drive(1'b0, 8'd127, 28'h4000000, 3'b001);
    wait_valid(lat);
    check("stall.lat", 32'(lat), 32'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_exp    = 8'd200;
      in_mantis = 28'h8000000;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      check("stall.res", out_result, 32'h3F800000);
      check("stall.valid", 32'(out_valid), 32'd1);
      check("stall.in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    $display("stall 5 cycles result=%h in_ready=%b", out_result, in_ready);
    release_out();
    check("stall.rdy", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("stall.ignored", 32'(out_valid), 32'd0);

    // Reset pulse while normalizing aborts the captured word.
    drive(1'b0, 8'd130, 28'h0000008, 3'b001);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    $display("midreset out_valid=%b in_ready=%b result=%h", out_valid, in_ready, out_result);
    check("midrst.valid", 32'(out_valid), 32'd0);
    check("midrst.in_ready", 32'(in_ready), 32'd1);
    check("midrst.result", out_result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("post_rst", 1'b0, 8'd127, 28'h4000000, 3'b001, 32'h3F800000, 4'b0000, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
